// File: rtl/bcd_pkg.sv
// Shared definitions for the binary<->BCD converter pair: FSM states, digit
// width and the double-dabble add-3 correction.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A digit of 5 or more would carry past 9 once doubled, so pre-add 3.
    function automatic logic [BCD_DIGIT_W-1:0] add3_adjust(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational per-digit correction applied to the BCD shift register
// before every shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = add3_adjust(digit_i);

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble converter: one binary bit per clock, results held
// in output registers between conversions.
module binary_to_bcd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [BIN_W-1:0]              binary_i,
    output logic                          ready_o,
    output logic                          done_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                          overflow_o
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   shift_next;
    logic               carry_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adjust (
            .digit_i (shift_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The bit leaving the top digit is worth 10^DIGITS and is discarded.
    assign shift_next = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    assign carry_out  = bcd_adj[BCD_W-1];

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        shift_d   = shift_q;
        count_d   = count_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    bin_d     = binary_i;
                    shift_d   = '0;
                    ovf_acc_d = 1'b0;
                    count_d   = CNT_LOAD;
                    state_d   = ST_OP;
                end
            end
            ST_OP: begin
                bin_d     = {bin_q[BIN_W-2:0], 1'b0};
                shift_d   = shift_next;
                ovf_acc_d = ovf_acc_q | carry_out;
                if (count_q == '0) begin
                    bcd_d   = shift_next;
                    ovf_d   = ovf_acc_q | carry_out;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            shift_q   <= '0;
            count_q   <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ready_o    = (state_q == ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign bcd_o      = bcd_q;
    assign overflow_o = ovf_q;

endmodule
